// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multi-cycle memory responder: FSM state encodings,
// operation type and default wait-state count.
package mem_responder_pkg;

  localparam int STATE_W          = 3;
  localparam int CNT_W            = 4;
  localparam int WAIT_CYCLES_DEF  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Synchronous single-port word array. The array itself is never reset; only the
// registered read port clears, so read data starts from a known zero.
module ram_array_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
  end

  // dout only moves on a read, so it holds the last read word between accesses
  always_ff @(posedge clock or posedge rst) begin
    if (rst)     dout <= '0;
    else if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a held Read/Write request, inserts WAIT_CYCLES
// wait states, performs one array access and pulses ready for one cycle.
//
//   state  | meaning
//   IDLE   | no request in flight, sampling Read/Write
//   WAIT   | counting down wait states with address/data latched
//   ACCESS | single array access edge; ready is set here
//   DONE   | ready high for this one cycle
//   HOLD   | waiting for the initiator to drop Read and Write
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;
  logic              ready_q, err_q;

  logic req_one, req_both, req_any;
  logic accept, ram_we, ram_re, ready_set, err_set;

  assign req_one  = Read ^ Write;
  assign req_both = Read & Write;
  assign req_any  = Read | Write;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_both)     state_d = S_HOLD;
        else if (req_one) state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT:   if (cnt_q <= CNT_W'(1)) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = req_any ? S_HOLD : S_IDLE;
      S_HOLD:   if (!req_any) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ready_set = 1'b0;
    err_set   = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        accept  = req_one;
        err_set = req_both;
      end
      S_ACCESS: begin
        ram_we    = (op_q == OP_WRITE);
        ram_re    = (op_q == OP_READ);
        ready_set = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured once in IDLE so the initiator may change or drop them later.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= WAIT_LOAD;
        addr_q  <= addr;
        wdata_q <= wdata;
        op_q    <= Write ? OP_WRITE : OP_READ;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      ready_q <= ready_set;
      err_q   <= err_set;
    end
  end

  ram_array_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .rst   (Reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .din   (wdata_q),
    .dout  (rdata)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule
